ram_n: RTL and testbench

Parametrised single-port word RAM, WIDTH bits by DEPTH words, generalising the fixed 8×16 RAM. It adds a hardware clear sequencer that fills every word with INIT_VAL after reset or on request, plus a busy flag. The block sits under the register-file and RAM hierarchy. It is a drop-in for small RAMs, keeping the same in/addr/write/out semantics plus clear control.

---
 rtl/ram_n_pkg.sv | 12 +
 rtl/ram_n_clear_seq.sv | 66 ++++++
 rtl/ram_n.sv | 84 ++++++++
 tb/tb_ram_n.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/ram_n_pkg.sv
// Shared types and default sizes for the ram_n word RAM and its clear sequencer.
package ram_n_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } ram_n_state_t;

    localparam int RAM_N_WIDTH = 16;
    localparam int RAM_N_DEPTH = 8;

endpackage

// File: rtl/ram_n_clear_seq.sv
// Clear sequencer for ram_n: walks every word once after reset or on a clear request
// and presents a write strobe/address for the INIT_VAL fill.
module ram_n_clear_seq
    import ram_n_pkg::*;
#(
    parameter int DEPTH = RAM_N_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    ram_n_state_t  state_reg, state_next;
    logic [AW-1:0] clr_ptr_reg, clr_ptr_next;
    logic          last_word;

    assign last_word = (clr_ptr_reg == AW'(DEPTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= CLEAR;
            clr_ptr_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_ptr_reg <= clr_ptr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_ptr_next = clr_ptr_reg;
        clr_we       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (clear) begin
                    state_next   = CLEAR;
                    clr_ptr_next = '0;
                end
            end
            CLEAR: begin
                clr_we = 1'b1;
                // A repeated request restarts the walk so busy spans DEPTH edges from it.
                if (clear) begin
                    clr_ptr_next = '0;
                end else if (last_word) begin
                    state_next   = IDLE;
                    clr_ptr_next = '0;
                end else begin
                    clr_ptr_next = clr_ptr_reg + AW'(1);
                end
            end
            default: begin
                state_next   = CLEAR;
                clr_ptr_next = '0;
            end
        endcase
    end

    assign busy     = (state_reg == CLEAR);
    assign clr_addr = clr_ptr_reg;

endmodule

// File: rtl/ram_n.sv
// Parametrised single-port WIDTH x DEPTH word RAM with asynchronous read and a hardware
// INIT_VAL clear sequence. Define RAM_N_BYPASS_EN for write-first read-during-write.
module ram_n
    import ram_n_pkg::*;
#(
    parameter int               WIDTH    = RAM_N_WIDTH,
    parameter int               DEPTH    = RAM_N_DEPTH,
    parameter int               AW       = $clog2(DEPTH),
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [AW-1:0]    addr,
    input  logic             write,
    input  logic             clear,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic                        clr_we;
    logic [AW-1:0]               clr_addr;
    logic                        addr_ok;
    logic                        user_we;
    logic                        mem_we;
    logic [AW-1:0]               mem_addr;
    logic [WIDTH-1:0]            mem_wdata;
    logic [DEPTH-1:0][WIDTH-1:0] rd_terms;
    logic [WIDTH-1:0]            rd_word;

    ram_n_clear_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Non-power-of-two depths leave address codes with no backing word.
    assign addr_ok = ({1'b0, addr} < (AW + 1)'(DEPTH));

    // The sequencer owns the write port whenever it runs; user writes are simply dropped.
    assign user_we   = write & ~busy & addr_ok;
    assign mem_we    = clr_we | user_we;
    assign mem_addr  = clr_we ? clr_addr : addr;
    assign mem_wdata = clr_we ? INIT_VAL : in;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rd_term
            assign rd_terms[gi] = (addr == AW'(gi)) ? mem[gi] : '0;
        end
    endgenerate

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_word = rd_word | rd_terms[i];
        end
    end

    always_comb begin
        out = '0;
        if (!busy && addr_ok) begin
`ifdef RAM_N_BYPASS_EN
            out = write ? in : rd_word;
`else
            out = rd_word;
`endif
        end
    end

endmodule

// File: tb/tb_ram_n.sv
// Self-checking bench for ram_n: an 8-word and a 5-word instance share stimulus and are
// compared against a word-array model with a busy countdown.
module tb_ram_n;

    localparam int          NDUT = 2;
    localparam logic [15:0] INIT8 = 16'hA5A5;
    localparam logic [15:0] INIT5 = 16'h5A5A;

    logic        clk;
    logic        rst8, rst5;
    logic [15:0] in;
    logic [2:0]  addr;
    logic        write, clear;
    logic [15:0] out8, out5;
    logic        busy8, busy5;

    int          passes = 0;
    int          checks = 0;

    logic [15:0] mmem [NDUT][8];
    int          bleft [NDUT];
    int          dep [NDUT];
    logic [15:0] ini [NDUT];

    ram_n #(.WIDTH(16), .DEPTH(8), .INIT_VAL(INIT8)) dut8 (
        .clk(clk), .reset(rst8), .in(in), .addr(addr), .write(write),
        .clear(clear), .out(out8), .busy(busy8)
    );

    ram_n #(.WIDTH(16), .DEPTH(5), .INIT_VAL(INIT5)) dut5 (
        .clk(clk), .reset(rst5), .in(in), .addr(addr), .write(write),
        .clear(clear), .out(out5), .busy(busy5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s t=%0t addr=%0d observed=%h expected=%h", tag, $time, addr, obs, exp);
    endtask

    // Clearing fills every word; the fill is hidden behind busy until it completes.
    task automatic start_clear(input int k);
        bleft[k] = dep[k];
        for (int j = 0; j < 8; j++) mmem[k][j] = ini[k];
    endtask

    function automatic logic [15:0] exp_out(input int k);
        if (bleft[k] != 0) return 16'h0;
        if (int'(addr) >= dep[k]) return 16'h0;
`ifdef RAM_N_BYPASS_EN
        if (write) return in;
`endif
        return mmem[k][addr];
    endfunction

    task automatic model_edge(input int k);
        if (bleft[k] != 0) begin
            bleft[k]--;
            if (clear) start_clear(k);
        end else begin
            if (write && int'(addr) < dep[k]) mmem[k][addr] = in;
            if (clear) start_clear(k);
        end
    endtask

    task automatic check_all(input string phase);
        chk({phase, "_out8"},  out8,  exp_out(0));
        chk({phase, "_busy8"}, {15'h0, busy8}, {15'h0, bleft[0] != 0});
        chk({phase, "_out5"},  out5,  exp_out(1));
        chk({phase, "_busy5"}, {15'h0, busy5}, {15'h0, bleft[1] != 0});
    endtask

    // One clock of stimulus, called just after a falling edge.
    task automatic step(input logic w, input logic [2:0] a, input logic [15:0] d,
                        input logic c, input logic r5);
        write = w; addr = a; in = d; clear = c;
        if (r5) begin
            rst5 = 1'b1;
            start_clear(1);
        end
        #1;
        check_all("pre");
        @(posedge clk);
        #1;
        model_edge(0);
        if (!r5) model_edge(1);
        if (r5) rst5 = 1'b0;
        #1;
        check_all("post");
        $display("step w=%0b a=%0d d=%h c=%0b r5=%0b out8=%h busy8=%0b out5=%h busy5=%0b",
                 w, a, d, c, r5, out8, busy8, out5, busy5);
        @(negedge clk);
    endtask

    initial begin
        dep[0] = 8; dep[1] = 5;
        ini[0] = INIT8; ini[1] = INIT5;
        rst8 = 1'b1; rst5 = 1'b1;
        write = 1'b0; clear = 1'b0; addr = '0; in = '0;
        #2;
        chk("rst_busy8", {15'h0, busy8}, 16'h1);
        chk("rst_out8", out8, 16'h0);
        chk("rst_busy5", {15'h0, busy5}, 16'h1);
        @(negedge clk);
        rst8 = 1'b0; rst5 = 1'b0;
        start_clear(0);
        start_clear(1);

        // Initial fill, with a write to addr 3 that must be dropped while busy.
        step(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 3'd3, 16'hFFFF, 1'b0, 1'b0);
        for (int i = 2; i < 8; i++) step(1'b0, 3'(i), 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 3'(i), 16'h0, 1'b0, 1'b0);

        step(1'b1, 3'd0, 16'h0070, 1'b0, 1'b0);
        step(1'b1, 3'd1, 16'h0065, 1'b0, 1'b0);
        step(1'b1, 3'd2, 16'h0063, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 3'(i), 16'h0, 1'b0, 1'b0);

        // Read-during-write on a populated word.
        step(1'b1, 3'd2, 16'h1234, 1'b0, 1'b0);
        step(1'b0, 3'd2, 16'h0, 1'b0, 1'b0);

        // Clear after populated writes, restarted part-way through.
        step(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 3'(i), 16'h0, 1'b0, 1'b0);
        step(1'b0, 3'd1, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 3'(i % 8), 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 3'(i), 16'h0, 1'b0, 1'b0);

        // Out-of-range address on the 5-word instance; writes plus clear together.
        step(1'b1, 3'd6, 16'hBEEF, 1'b0, 1'b0);
        step(1'b1, 3'd4, 16'h4444, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 3'(i), 16'h0, 1'b0, 1'b0);
        step(1'b1, 3'd1, 16'h7777, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 3'd1, 16'h0, 1'b0, 1'b0);

        // Reset the 5-word instance with its clear pointer at 3.
        step(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 3'(i), 16'h0, 1'b0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                 1'($urandom_range(0, 24) == 0), 1'b0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
